sobel_stream: RTL and testbench
===============================

# sobel_stream

Parametrised streaming Sobel edge detector. Accepts one raster-order pixel per qualified cycle, holds two image rows in internal line buffers, forms a 3x3 window, and computes horizontal and vertical gradients, a saturated L1 magnitude and a thresholded edge flag. Supersedes the fixed 5x5, single-kernel convolution stage. Adds true Gx/Gy kernels, input gaps, frame resync and an end-of-frame marker.

## Interface

**Parameters**
- `IMG_W`, default 5: image columns, ≥ 3.
- `IMG_H`, default 5: image rows, ≥ 3.
- `PXL_W`, default 8: unsigned pixel width.
- `MAG_W`, default 11: magnitude width; saturating.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `pxl_in`, in, `PXL_W`: input pixel.
- `pxl_valid`, in, 1: `pxl_in` is accepted this cycle.
- `sof`, in, 1: qualified by `pxl_valid`; this pixel is (row 0, col 0).
- `thresh`, in, `MAG_W`: edge threshold, sampled every cycle.
- `gx`, out, `PXL_W+3` signed: horizontal gradient.
- `gy`, out, `PXL_W+3` signed: vertical gradient.
- `mag`, out, `MAG_W`: min(|gx|+|gy|, 2^MAG_W−1).
- `edge`, out, 1: `mag >= thresh`.
- `valid`, out, 1: one-cycle pulse; outputs describe one interior pixel.
- `eof`, out, 1: asserted with `valid` for the last interior pixel of a frame.

## Operation

- Counters `col` (0..IMG_W−1) and `row` (0..IMG_H−1) advance only on an accepted pixel.
  - `col` wraps to 0 and increments `row`.
  - After (IMG_H−1, IMG_W−1), both wrap to 0.
  - Counter width is `$clog2` of the bound.
- On `pxl_valid && sof`, the pixel is taken as (0,0) regardless of counter state. Counters restart from there.
- Line buffers: two FIFOs of depth `IMG_W` × `PXL_W`. They shift only on acceptance. Line buffer 1 feeds line buffer 0.
- Window `w[r][c]`: r=0 is the oldest row, c=2 is the newest column. It shifts left on acceptance.
  - Column 2 loads {lb0 out, lb1 out, `pxl_in`}.
- Output condition: the accepted pixel has `row >= 2 && col >= 2`. The window centre is then (row−1, col−1).
- Gradients:
  - Gx = (w02 + 2·w12 + w22) − (w00 + 2·w10 + w20)
  - Gy = (w20 + 2·w21 + w22) − (w00 + 2·w01 + w02)
  - Both are exact in `PXL_W+3` signed bits; range ±4·(2^PXL_W−1).
- `mag` = |Gx| + |Gy|, computed in `PXL_W+3` bits, then clamped to all-ones if it does not fit in `MAG_W`.
- `eof` is set when the qualifying pixel is (IMG_H−1, IMG_W−1).
- Each frame produces exactly (IMG_H−2)·(IMG_W−2) `valid` pulses. Border pixels produce no output.
- Rows 0–1 of a new frame never produce output, so stale line-buffer contents are don't-care.
- No back-pressure. Outputs must be consumed on the `valid` cycle.

## Timing

- Reset values: all outputs 0; counters 0; window registers 0. Line-buffer RAM contents are unreset.
- Pipeline:
  - Edge t accepts the pixel and updates the window and an internal `hit` flag.
  - Edge t+1 registers `gx`, `gy`, `mag`, `edge`, `valid`, `eof`.
  - Latency: outputs are visible 2 edges after the pixel is presented.
- The output stage advances every cycle. `valid` is 0 in any cycle whose preceding edge had no qualifying acceptance.
- Output registers other than `valid`/`eof` hold their last value when `valid` is 0.
- Gaps in `pxl_valid` freeze the counters, line buffers and window. They do not alter results; output pulses are spaced by the gaps.
- `sof` together with a mid-frame pixel truncates the current frame without `eof`. Any output already in the pipeline still emerges.
- `reset` asserted mid-frame: all state clears immediately, including in-flight `valid`. The first pixel accepted after release is (0,0) whether or not `sof` is set.
- `sof` without `pxl_valid` is ignored.

## Structure

- Package `sobel_pkg`: kernel coefficient constants (`KX`, `KY` as 3x3 signed localparam arrays) and a `grad_w(PXL_W)` function returning `PXL_W+3`.
- Sub-module `line_buffer`: parametrised by depth and width, with shift enable. Instantiated twice.
- Counters, window, arithmetic and output registers live in `sobel_stream`.

## Test plan

- **Constant frame:** 5x5, all pixels 100, continuous `pxl_valid`.
  - Expect exactly 9 `valid` pulses; `gx=gy=mag=0`; `eof` on the 9th only.
- **Vertical step:** columns 0–1 = 0, columns 2–4 = 255, `thresh`=500.
  - Per row, expect `gx`=1020, 1020, 0; `gy`=0; `edge`=1, 1, 0.
- **Horizontal step with saturation:** rows 0–1 = 0, rows 2–4 = 255, `MAG_W`=8.
  - Expect `gy`=1020 and `mag`=255 for centre rows 1 and 2.
- **Random stall:** `pxl_valid` toggled randomly on a 16x8 random image.
  - Outputs must match the continuous-stream golden model in value and order.
- **Frame resync:** `sof` asserted at pixel (2,3) of a frame.
  - No `eof` for the truncated frame; the following full frame yields 9 correct outputs.
- **Reset mid-frame:** `reset` asserted at pixel (3,2).
  - All outputs 0 within the reset cycle; the next frame yields 9 outputs with correct values.

Source files
------------

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared constants and helpers for the streaming Sobel edge detector.
//   KX, KY : 3x3 Sobel kernels indexed [row][col]; row 0 is the oldest image
//            row in the window and col 2 the newest column.
//   grad_w : width of a signed gradient for a given pixel width.
package sobel_pkg;

   localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
   localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

   // Three extra bits cover the kernel gain of 4 plus the sign.
   function automatic int grad_w(input int pxl_w);
      return pxl_w + 3;
   endfunction

endpackage

// File: rtl/line_buffer.sv
// line_buffer: fixed-depth shift FIFO holding one image row.
//   clk      : clock
//   shift_en : advance the row by one entry (one accepted pixel)
//   din      : entry written at the head
//   dout     : entry written DEPTH shifts ago
// Storage is data only and is deliberately left unreset.
module line_buffer #(
   parameter int DEPTH = 5,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (shift_en) begin
         mem_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector over a raster pixel stream.
//   clk, reset : clock, asynchronous active-high reset
//   pxl_in     : input pixel, accepted when pxl_valid is high
//   pxl_valid  : pixel qualifier; gaps freeze all image state
//   sof        : with pxl_valid, marks the pixel as row 0 / col 0
//   thresh     : edge threshold, compared against mag every cycle
//   gx, gy     : signed horizontal / vertical gradients of the window centre
//   mag        : |gx|+|gy| saturated to MAG_W bits
//   edge_out   : mag >= thresh
//   valid      : one-cycle pulse per interior pixel
//   eof        : with valid, last interior pixel of the frame
module sobel_stream
   import sobel_pkg::*;
#(
   parameter int IMG_W = 5,
   parameter int IMG_H = 5,
   parameter int PXL_W = 8,
   parameter int MAG_W = 11
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PXL_W-1:0]        pxl_in,
   input  logic                    pxl_valid,
   input  logic                    sof,
   input  logic [MAG_W-1:0]        thresh,
   output logic signed [PXL_W+2:0] gx,
   output logic signed [PXL_W+2:0] gy,
   output logic [MAG_W-1:0]        mag,
   output logic                    edge_out,
   output logic                    valid,
   output logic                    eof
);

   localparam int GW = grad_w(PXL_W);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   function automatic logic [GW-1:0] abs_grad(input logic signed [GW-1:0] v);
      if (v < 0) return -v;
      return v;
   endfunction

   function automatic logic [MAG_W-1:0] sat_mag(input logic [GW-1:0] s);
      logic [GW+MAG_W-1:0] wide;
      wide = {{MAG_W{1'b0}}, s};
      if (wide > {{GW{1'b0}}, {MAG_W{1'b1}}}) return '1;
      return wide[MAG_W-1:0];
   endfunction

   logic [CW-1:0]    col_q, col_d, col_cur;
   logic [RW-1:0]    row_q, row_d, row_cur;
   logic [PXL_W-1:0] win_q [3][3];
   logic [PXL_W-1:0] win_d [3][3];
   logic             hit_q, hit_d;
   logic             last_q, last_d;
   logic [PXL_W-1:0] lb1_out, lb0_out;

   logic signed [GW-1:0] gx_c, gy_c, pix;
   logic [GW-1:0]        sum_c;
   logic [MAG_W-1:0]     mag_c;

   logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
   logic [MAG_W-1:0]     mag_q, mag_d;
   logic                 edge_q, edge_d, valid_q, valid_d, eof_q, eof_d;

   // lb1 holds the previous row, lb0 the row before it.
   line_buffer #(.DEPTH(IMG_W), .WIDTH(PXL_W)) u_lb1 (
      .clk      (clk),
      .shift_en (pxl_valid),
      .din      (pxl_in),
      .dout     (lb1_out)
   );

   line_buffer #(.DEPTH(IMG_W), .WIDTH(PXL_W)) u_lb0 (
      .clk      (clk),
      .shift_en (pxl_valid),
      .din      (lb1_out),
      .dout     (lb0_out)
   );

   // ---- stage 0: pixel acceptance, raster position, window ----
   always_comb begin
      // sof forces this pixel to (0,0) irrespective of the running position.
      col_cur = sof ? '0 : col_q;
      row_cur = sof ? '0 : row_q;
      col_d   = col_q;
      row_d   = row_q;
      win_d   = win_q;
      hit_d   = 1'b0;
      last_d  = 1'b0;
      if (pxl_valid) begin
         if (col_cur == COL_LAST) begin
            col_d = '0;
            row_d = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
         end else begin
            col_d = col_cur + CW'(1);
            row_d = row_cur;
         end
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb0_out;
         win_d[1][2] = lb1_out;
         win_d[2][2] = pxl_in;
         hit_d  = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
         last_d = hit_d && (row_cur == ROW_LAST) && (col_cur == COL_LAST);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q  <= '0;
         row_q  <= '0;
         hit_q  <= 1'b0;
         last_q <= 1'b0;
         for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
               win_q[r][c] <= '0;
            end
         end
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         hit_q  <= hit_d;
         last_q <= last_d;
         win_q  <= win_d;
      end
   end

   // ---- stage 1: gradients, magnitude, threshold, output registers ----
   always_comb begin
      gx_c = '0;
      gy_c = '0;
      pix  = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            pix  = $signed({3'b000, win_q[r][c]});
            gx_c = gx_c + GW'(KX[r][c]) * pix;
            gy_c = gy_c + GW'(KY[r][c]) * pix;
         end
      end
      // Cannot overflow: 8*(2^PXL_W-1) < 2^GW.
      sum_c = abs_grad(gx_c) + abs_grad(gy_c);
      mag_c = sat_mag(sum_c);
   end

   always_comb begin
      gx_d    = hit_q ? gx_c : gx_q;
      gy_d    = hit_q ? gy_c : gy_q;
      mag_d   = hit_q ? mag_c : mag_q;
      edge_d  = hit_q ? (mag_c >= thresh) : edge_q;
      valid_d = hit_q;
      eof_d   = last_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gx_q    <= '0;
         gy_q    <= '0;
         mag_q   <= '0;
         edge_q  <= 1'b0;
         valid_q <= 1'b0;
         eof_q   <= 1'b0;
      end else begin
         gx_q    <= gx_d;
         gy_q    <= gy_d;
         mag_q   <= mag_d;
         edge_q  <= edge_d;
         valid_q <= valid_d;
         eof_q   <= eof_d;
      end
   end

   assign gx       = gx_q;
   assign gy       = gy_q;
   assign mag      = mag_q;
   assign edge_out = edge_q;
   assign valid    = valid_q;
   assign eof      = eof_q;

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: directed bench for sobel_stream. Instances A (5x5, MAG_W 11)
// and B (5x5, MAG_W 8) share one stimulus stream; instance C (16x8) takes a
// randomly gapped stream. Expected outputs come from a centre-pixel model of
// the Sobel operator over whole-frame image arrays.
module tb_sobel_stream;

   typedef struct {
      int gx;
      int gy;
      int mag;
      int mag_b;
      int edg;
      int eof;
   } out_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]         pxl_a, pxl_c;
   logic               pv_a, sof_a, pv_c, sof_c;
   logic [10:0]        thr_a, thr_c;
   logic signed [10:0] gx_a, gy_a, gx_b, gy_b, gx_c, gy_c;
   logic [10:0]        mag_a, mag_c;
   logic [7:0]         mag_b;
   logic               edge_a, valid_a, eof_a;
   logic               edge_b, valid_b, eof_b;
   logic               edge_c, valid_c, eof_c;

   sobel_stream #(.IMG_W(5), .IMG_H(5), .PXL_W(8), .MAG_W(11)) dut_a (
      .clk(clk), .reset(reset), .pxl_in(pxl_a), .pxl_valid(pv_a), .sof(sof_a),
      .thresh(thr_a), .gx(gx_a), .gy(gy_a), .mag(mag_a), .edge_out(edge_a),
      .valid(valid_a), .eof(eof_a)
   );

   sobel_stream #(.IMG_W(5), .IMG_H(5), .PXL_W(8), .MAG_W(8)) dut_b (
      .clk(clk), .reset(reset), .pxl_in(pxl_a), .pxl_valid(pv_a), .sof(sof_a),
      .thresh(thr_a[7:0]), .gx(gx_b), .gy(gy_b), .mag(mag_b), .edge_out(edge_b),
      .valid(valid_b), .eof(eof_b)
   );

   sobel_stream #(.IMG_W(16), .IMG_H(8), .PXL_W(8), .MAG_W(11)) dut_c (
      .clk(clk), .reset(reset), .pxl_in(pxl_c), .pxl_valid(pv_c), .sof(sof_c),
      .thresh(thr_c), .gx(gx_c), .gy(gy_c), .mag(mag_c), .edge_out(edge_c),
      .valid(valid_c), .eof(eof_c)
   );

   int   n_tests = 0;
   int   n_fail  = 0;
   int   img [8][16];
   out_t exp_a[$], exp_c[$], log_a[$], log_c[$];
   out_t ga, ea, gc, ec;

   task automatic chk(input string nm, input int act, input int req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, req);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Centre-based Sobel over img; an output exists for every interior centre
   // whose bottom-right neighbour lies among the first npix pixels sent.
   task automatic model_frame(input int w, input int h, input int npix,
                              input int thr, input bit to_c);
      for (int r = 1; r < h - 1; r++) begin
         for (int c = 1; c < w - 1; c++) begin
            out_t e;
            int   last;
            last = (r + 1) * w + (c + 1);
            if (last < npix) begin
               e.gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
                    - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
               e.gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
                    - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
               e.mag   = imin(iabs(e.gx) + iabs(e.gy), 2047);
               e.mag_b = imin(iabs(e.gx) + iabs(e.gy), 255);
               e.edg   = (e.mag >= thr) ? 1 : 0;
               e.eof   = (last == w * h - 1) ? 1 : 0;
               if (to_c) exp_c.push_back(e);
               else      exp_a.push_back(e);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      pv_a  = 1'b0;
      sof_a = 1'b0;
      pv_c  = 1'b0;
      sof_c = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send_a(input int w, input int npix, input bit first_sof);
      for (int i = 0; i < npix; i++) begin
         pv_a  = 1'b1;
         pxl_a = 8'(img[i / w][i % w]);
         sof_a = first_sof && (i == 0);
         tick();
      end
      pv_a  = 1'b0;
      sof_a = 1'b0;
   endtask

   // Random gaps; sof toggles freely while pxl_valid is low.
   task automatic send_c(input int npix);
      for (int i = 0; i < npix; i++) begin
         int g;
         g = $urandom_range(0, 2);
         repeat (g) begin
            pv_c  = 1'b0;
            pxl_c = 8'($urandom);
            sof_c = 1'($urandom);
            tick();
         end
         pv_c  = 1'b1;
         pxl_c = 8'(img[i / 16][i % 16]);
         sof_c = (i == 0);
         tick();
      end
      pv_c  = 1'b0;
      sof_c = 1'b0;
   endtask

   task automatic fill_random();
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 16; c++) begin
            img[r][c] = $urandom_range(0, 255);
         end
      end
   endtask

   function automatic int eof_cnt_a();
      int n = 0;
      foreach (log_a[i]) n += log_a[i].eof;
      return n;
   endfunction

   function automatic int eof_cnt_c();
      int n = 0;
      foreach (log_c[i]) n += log_c[i].eof;
      return n;
   endfunction

   always @(negedge clk) begin
      if (valid_a || valid_b) begin
         chk("b_valid_vs_a", int'(valid_b), int'(valid_a));
      end
      if (valid_a) begin
         ga.gx    = int'(gx_a);
         ga.gy    = int'(gy_a);
         ga.mag   = int'(mag_a);
         ga.mag_b = int'(mag_b);
         ga.edg   = int'(edge_a);
         ga.eof   = int'(eof_a);
         log_a.push_back(ga);
         if (exp_a.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid_a: got valid=1, expected no output");
         end else begin
            ea = exp_a.pop_front();
            chk("a_gx", ga.gx, ea.gx);
            chk("a_gy", ga.gy, ea.gy);
            chk("a_mag", ga.mag, ea.mag);
            chk("a_edge", ga.edg, ea.edg);
            chk("a_eof", ga.eof, ea.eof);
            chk("b_gx", int'(gx_b), ea.gx);
            chk("b_gy", int'(gy_b), ea.gy);
            chk("b_mag", ga.mag_b, ea.mag_b);
            chk("b_eof", int'(eof_b), ea.eof);
         end
      end
      if (valid_c) begin
         gc.gx    = int'(gx_c);
         gc.gy    = int'(gy_c);
         gc.mag   = int'(mag_c);
         gc.mag_b = 0;
         gc.edg   = int'(edge_c);
         gc.eof   = int'(eof_c);
         log_c.push_back(gc);
         if (exp_c.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_valid_c: got valid=1, expected no output");
         end else begin
            ec = exp_c.pop_front();
            chk("c_gx", gc.gx, ec.gx);
            chk("c_gy", gc.gy, ec.gy);
            chk("c_mag", gc.mag, ec.mag);
            chk("c_edge", gc.edg, ec.edg);
            chk("c_eof", gc.eof, ec.eof);
         end
      end
   end

   initial begin
      pv_a  = 1'b0; sof_a = 1'b0; pxl_a = '0; thr_a = '0;
      pv_c  = 1'b0; sof_c = 1'b0; pxl_c = '0; thr_c = 11'd600;
      reset = 1'b1;
      repeat (2) tick();

      chk("rst_gx", int'(gx_a), 0);
      chk("rst_gy", int'(gy_a), 0);
      chk("rst_mag", int'(mag_a), 0);
      chk("rst_edge", int'(edge_a), 0);
      chk("rst_valid", int'(valid_a), 0);
      chk("rst_eof", int'(eof_a), 0);
      chk("rst_valid_c", int'(valid_c), 0);
      reset = 1'b0;
      idle(2);

      // Constant frame
      thr_a = 11'd1;
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = 100;
      log_a.delete();
      model_frame(5, 5, 25, int'(thr_a), 1'b0);
      send_a(5, 25, 1'b1);
      idle(4);
      chk("const_count", log_a.size(), 9);
      chk("const_eofs", eof_cnt_a(), 1);
      if (log_a.size() == 9) begin
         chk("const_eof_last", log_a[8].eof, 1);
         for (int i = 0; i < 9; i++) begin
            chk("const_zero", iabs(log_a[i].gx) + iabs(log_a[i].gy) + log_a[i].mag, 0);
         end
      end

      // Vertical step
      thr_a = 11'd500;
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = (c >= 2) ? 255 : 0;
      log_a.delete();
      model_frame(5, 5, 25, int'(thr_a), 1'b0);
      send_a(5, 25, 1'b1);
      idle(4);
      chk("vstep_count", log_a.size(), 9);
      if (log_a.size() == 9) begin
         for (int r = 0; r < 3; r++) begin
            chk("vstep_gx0", log_a[3*r].gx, 1020);
            chk("vstep_gx1", log_a[3*r+1].gx, 1020);
            chk("vstep_gx2", log_a[3*r+2].gx, 0);
            chk("vstep_gy", log_a[3*r].gy, 0);
            chk("vstep_edge0", log_a[3*r].edg, 1);
            chk("vstep_edge1", log_a[3*r+1].edg, 1);
            chk("vstep_edge2", log_a[3*r+2].edg, 0);
         end
         chk("vstep_mag", log_a[0].mag, 1020);
         chk("vstep_mag_sat", log_a[0].mag_b, 255);
      end

      // Horizontal step, saturation on the MAG_W=8 instance
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = (r >= 2) ? 255 : 0;
      log_a.delete();
      model_frame(5, 5, 25, int'(thr_a), 1'b0);
      send_a(5, 25, 1'b1);
      idle(4);
      chk("hstep_count", log_a.size(), 9);
      if (log_a.size() == 9) begin
         chk("hstep_gy_r1", log_a[0].gy, 1020);
         chk("hstep_gy_r2", log_a[4].gy, 1020);
         chk("hstep_gy_r3", log_a[6].gy, 0);
         chk("hstep_gx", log_a[1].gx, 0);
         chk("hstep_mag_sat_r1", log_a[0].mag_b, 255);
         chk("hstep_mag_sat_r2", log_a[5].mag_b, 255);
         chk("hstep_mag_full", log_a[2].mag, 1020);
      end

      // Frame resync: sof arrives where pixel (2,3) would be
      fill_random();
      log_a.delete();
      model_frame(5, 5, 13, int'(thr_a), 1'b0);
      send_a(5, 13, 1'b1);
      fill_random();
      model_frame(5, 5, 25, int'(thr_a), 1'b0);
      send_a(5, 25, 1'b1);
      idle(4);
      chk("resync_count", log_a.size(), 10);
      chk("resync_eofs", eof_cnt_a(), 1);
      if (log_a.size() == 10) begin
         chk("resync_trunc_no_eof", log_a[0].eof, 0);
         chk("resync_eof_last", log_a[9].eof, 1);
      end

      // Reset mid-frame right after pixel (3,2) is accepted
      fill_random();
      log_a.delete();
      model_frame(5, 5, 17, int'(thr_a), 1'b0);
      send_a(5, 18, 1'b1);
      reset = 1'b1;
      #1;
      chk("mrst_gx", int'(gx_a), 0);
      chk("mrst_gy", int'(gy_a), 0);
      chk("mrst_mag", int'(mag_a), 0);
      chk("mrst_edge", int'(edge_a), 0);
      chk("mrst_valid", int'(valid_a), 0);
      chk("mrst_eof", int'(eof_a), 0);
      chk("mrst_mag_b", int'(mag_b), 0);
      repeat (2) tick();
      reset = 1'b0;
      idle(3);
      chk("mrst_pre_count", log_a.size(), 3);
      fill_random();
      model_frame(5, 5, 25, int'(thr_a), 1'b0);
      send_a(5, 25, 1'b0);
      idle(4);
      chk("mrst_total_count", log_a.size(), 12);
      chk("mrst_eofs", eof_cnt_a(), 1);

      // Random stall on the 16x8 instance
      fill_random();
      log_c.delete();
      model_frame(16, 8, 128, int'(thr_c), 1'b1);
      send_c(128);
      idle(4);
      chk("stall_count", log_c.size(), 84);
      chk("stall_eofs", eof_cnt_c(), 1);

      chk("pending_a", exp_a.size(), 0);
      chk("pending_c", exp_c.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
